ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised multi-cycle control sequencer for the lab CPU. It accepts one opcode per valid/ready handshake and classifies it as halt, unconditional jump, conditional jump-on-zero or ordinary execute. It then drives the clock-disable, jump-enable, pipeline-flush and execute-enable strobes over a fixed cycle schedule, and counts retired instructions. It sits between the instruction fetch stage and the datapath/PC logic, replacing the purely combinational opcode decoder.

## Interface
- OPW, 4: opcode width in bits.
- OP_HALT, 4'b0000: opcode that stops the machine (clock disable).
- OP_JMP, 4'b0100: unconditional jump opcode.
- OP_JZ, 4'b0011: jump-if-zero opcode.
- FLUSH_CYC, 2: number of cycles `flush` is held after a taken jump; legal range 1..15.
- CNT_W, 8: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instr_valid  in  1  fetch stage presents an opcode.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- opcode  in  OPW  opcode; sampled only on the accept edge.
- zero_flag  in  1  ALU zero flag; sampled only in DECODE.
- resume  in  1  leave HALT; ignored in every other state.
- clk_dis  out  1  datapath clock-disable; high throughout HALT.
- jump_en  out  1  PC load strobe; high for the first JUMP cycle only.
- flush  out  1  pipeline flush; high for all FLUSH_CYC JUMP cycles.
- exec_en  out  1  datapath execute strobe; high for the single EXEC cycle.
- instr_cnt  out  CNT_W  retired-instruction count.

## Operation
- States: IDLE, DECODE, EXEC, JUMP, HALT. The state register and the latched opcode are flops.
- All outputs are decoded from the current state or counters only, never from inputs, so they are glitch-free Moore outputs.
- Reset (rst_n low, asynchronous):
  - state = IDLE, flush counter = 0, instr_cnt = 0.
  - clk_dis = jump_en = flush = exec_en = 0; instr_ready = 1.
  - instr_valid is ignored while rst_n is low.
  - Reset mid-operation (including HALT or JUMP) aborts immediately to these values.
- IDLE:
  - instr_ready = 1.
  - When instr_valid && instr_ready at an edge: latch opcode and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE (exactly one cycle):
  - opcode == OP_HALT: go to HALT.
  - opcode == OP_JMP, or opcode == OP_JZ && zero_flag == 1: go to JUMP and load the flush counter with FLUSH_CYC-1.
  - All other cases go to EXEC. This includes OP_JZ with zero_flag == 0 (not-taken branch) and every undefined opcode.
- EXEC:
  - exec_en = 1.
  - Next state is IDLE; instr_cnt increments.
- JUMP:
  - flush = 1 every cycle.
  - jump_en = 1 only while the counter equals FLUSH_CYC-1, i.e. the first JUMP cycle.
  - Counter decrements each cycle. When it reaches 0, go to IDLE and increment instr_cnt.
- HALT:
  - clk_dis = 1.
  - instr_cnt increments once, on entry.
  - Stay in HALT until resume = 1 at an edge, then go to IDLE.
  - resume held high continuously does not cause re-entry or a double count.
- instr_cnt arithmetic: unsigned, modulo 2^CNT_W; wraps from all-ones to 0 with no flag.
- Opcode and zero_flag changes outside their sampling points have no effect.

## Timing
Accept edge is edge k; the state listed is the state held after the named edge.
- Execute: DECODE after k, EXEC after k+1 (exec_en high for one cycle), IDLE after k+2. Throughput is one instruction per 3 cycles with valid held high.
- Jump: JUMP after k+1; jump_en high for one cycle; flush high for FLUSH_CYC cycles; IDLE after k+1+FLUSH_CYC.
- Halt: clk_dis high from k+1. It drops on the edge after resume is sampled high, and the next accept is possible one cycle later.
- instr_cnt updates on the same edge that leaves EXEC or JUMP, or that enters HALT.
- instr_ready drops on the accept edge and is low for the whole instruction. Back-to-back accepts are impossible.

## Test plan
- Reset/idle: hold rst_n = 0, then release with instr_valid = 0 -> all strobes 0, instr_ready = 1, instr_cnt = 0. Assert rst_n = 0 mid-JUMP -> outputs return to reset values without waiting for a clock edge.
- Execute: accept opcode 4'b1111 -> exec_en high for exactly 1 cycle, 2 cycles after accept; instr_cnt = 1; jump_en, flush and clk_dis stay 0.
- Jump: accept 4'b0100 with FLUSH_CYC = 2 -> jump_en high for 1 cycle, flush high for 2 cycles, instr_ready back high 4 cycles after accept.
- Conditional: accept 4'b0011 with zero_flag = 1 in DECODE -> jump sequence. Repeat with zero_flag = 0 -> exec_en only. Toggle zero_flag outside DECODE -> no effect.
- Halt: accept 4'b0000 -> clk_dis stays high for 20 cycles while instr_valid = 1 and instr_ready = 0. Pulse resume -> clk_dis falls on the next edge and the next opcode is accepted; instr_cnt increased by exactly 1.
- Wrap: with CNT_W = 2, retire 5 instructions -> instr_cnt sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//
// Multi-cycle control sequencer sitting between instruction fetch and the
// datapath/PC logic. One opcode is accepted per valid/ready handshake and
// classified as halt, unconditional jump, taken/not-taken jump-on-zero or
// ordinary execute. The matching strobe schedule is then played out, and
// retired instructions are counted.
//
// Ports:
//   clk          in   system clock, rising edge active
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   fetch stage presents an opcode
//   instr_ready  out  sequencer can accept (IDLE only)
//   opcode       in   opcode, captured on the accept edge
//   zero_flag    in   ALU zero flag, looked at only in DECODE
//   resume       in   leave HALT (ignored elsewhere)
//   clk_dis      out  datapath clock-disable, high throughout HALT
//   jump_en      out  PC load strobe, first JUMP cycle only
//   flush        out  pipeline flush, every JUMP cycle
//   exec_en      out  datapath execute strobe, the single EXEC cycle
//   instr_cnt    out  retired-instruction count, wraps modulo 2^CNT_W
module ctrl_sequencer #(
    parameter int              OPW       = 4,
    parameter logic [OPW-1:0]  OP_HALT   = 4'b0000,
    parameter logic [OPW-1:0]  OP_JMP    = 4'b0100,
    parameter logic [OPW-1:0]  OP_JZ     = 4'b0011,
    parameter int              FLUSH_CYC = 2,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero_flag,
    input  logic             resume,
    output logic             clk_dis,
    output logic             jump_en,
    output logic             flush,
    output logic             exec_en,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        JUMP,
        HALT
    } state_t;

    // The flush counter counts down from FLUSH_CYC-1 to 0, so the value it
    // is loaded with also marks the first JUMP cycle.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [OPW-1:0]   op_q;
    logic [3:0]       flush_cnt;
    logic [3:0]       flush_cnt_next;
    logic             cnt_inc;
    logic             jump_taken;

    // State, flush counter and retired count. The count steps on the edge
    // that leaves EXEC or JUMP, or that enters HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            instr_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (cnt_inc) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // The opcode is captured only on the accept edge so later changes on
    // the fetch bus cannot alter the instruction being sequenced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (instr_valid && (state == IDLE)) begin
            op_q <= opcode;
        end
    end

    // Next-state and counter control. zero_flag only matters in DECODE and
    // resume only in HALT; anything that is neither halt nor a taken jump
    // (including undefined opcodes) is treated as an ordinary execute.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        cnt_inc        = 1'b0;
        jump_taken     = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_flag);

        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (op_q == OP_HALT) begin
                    state_next = HALT;
                    cnt_inc    = 1'b1;
                end else if (jump_taken) begin
                    state_next     = JUMP;
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                cnt_inc    = 1'b1;
            end
            JUMP: begin
                if (flush_cnt == 4'd0) begin
                    state_next = IDLE;
                    cnt_inc    = 1'b1;
                end else begin
                    flush_cnt_next = flush_cnt - 4'd1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from state and counter only.
    assign instr_ready = (state == IDLE);
    assign clk_dis     = (state == HALT);
    assign exec_en     = (state == EXEC);
    assign flush       = (state == JUMP);
    assign jump_en     = (state == JUMP) && (flush_cnt == FLUSH_LOAD);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer
//
// Self-checking bench for ctrl_sequencer. Two instances share all inputs:
// one with the default 8-bit counter and one with a 2-bit counter so that
// counter wrap-around is exercised. A vector table covers the basic
// opcode classes, hand-written sequences cover long HALT, asynchronous
// reset mid-JUMP and counter wrap, and a random run is compared against
// an instruction-level reference model.
module tb_ctrl_sequencer;

    localparam int FLUSH_CYC = 2;

    // Expected strobe vectors, packed as {ready, clk_dis, jump_en, flush, exec_en}.
    localparam logic [4:0] O_IDLE  = 5'b10000;
    localparam logic [4:0] O_BUSY  = 5'b00000;
    localparam logic [4:0] O_EXEC  = 5'b00001;
    localparam logic [4:0] O_JMP1  = 5'b00110;
    localparam logic [4:0] O_JMPN  = 5'b00010;
    localparam logic [4:0] O_HALT  = 5'b01000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       resume;

    logic       instr_ready, clk_dis, jump_en, flush, exec_en;
    logic [7:0] instr_cnt;
    logic       w_instr_ready, w_clk_dis, w_jump_en, w_flush, w_exec_en;
    logic [1:0] w_instr_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(
        .OPW(4), .OP_HALT(4'b0000), .OP_JMP(4'b0100), .OP_JZ(4'b0011),
        .FLUSH_CYC(FLUSH_CYC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .zero_flag(zero_flag),
        .resume(resume), .clk_dis(clk_dis), .jump_en(jump_en),
        .flush(flush), .exec_en(exec_en), .instr_cnt(instr_cnt)
    );

    ctrl_sequencer #(
        .OPW(4), .OP_HALT(4'b0000), .OP_JMP(4'b0100), .OP_JZ(4'b0011),
        .FLUSH_CYC(FLUSH_CYC), .CNT_W(2)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instr_ready(w_instr_ready), .opcode(opcode), .zero_flag(zero_flag),
        .resume(resume), .clk_dis(w_clk_dis), .jump_en(w_jump_en),
        .flush(w_flush), .exec_en(w_exec_en), .instr_cnt(w_instr_cnt)
    );

    // Reference model: tracks the instruction in flight rather than a state
    // machine. An accepted opcode spends one cycle being classified, then
    // its strobe schedule is queued cycle by cycle; the instruction retires
    // when its schedule runs out, or immediately on entering halt.
    logic [4:0]  sched[$];
    bit          m_halt;
    bit          m_decode;
    logic [3:0]  m_op;
    int unsigned retired;

    task automatic modelReset();
        sched.delete();
        m_halt   = 1'b0;
        m_decode = 1'b0;
        m_op     = 4'd0;
        retired  = 0;
    endtask

    function automatic logic [4:0] modelOuts();
        if (m_halt)             return O_HALT;
        if (m_decode)           return O_BUSY;
        if (sched.size() != 0)  return sched[0];
        return O_IDLE;
    endfunction

    task automatic modelAdvance(input logic v, input logic [3:0] op,
                                input logic zf, input logic res);
        if (m_halt) begin
            if (res) m_halt = 1'b0;
        end else if (m_decode) begin
            m_decode = 1'b0;
            if (m_op == 4'b0000) begin
                m_halt = 1'b1;
                retired++;
            end else if (m_op == 4'b0100 || (m_op == 4'b0011 && zf)) begin
                for (int i = 0; i < FLUSH_CYC; i++)
                    sched.push_back((i == 0) ? O_JMP1 : O_JMPN);
            end else begin
                sched.push_back(O_EXEC);
            end
        end else if (sched.size() != 0) begin
            void'(sched.pop_front());
            if (sched.size() == 0) retired++;
        end else if (v) begin
            m_decode = 1'b1;
            m_op     = op;
        end
    endtask

    // Compares both instances' strobes and counters against expectations.
    task automatic checkOutput(input string name, input logic [4:0] exp_outs,
                               input logic [7:0] exp_cnt);
        logic [4:0] act;
        logic [4:0] w_act;
        act   = {instr_ready, clk_dis, jump_en, flush, exec_en};
        w_act = {w_instr_ready, w_clk_dis, w_jump_en, w_flush, w_exec_en};
        vectors++;
        if (act !== exp_outs) begin
            miscompares++;
            $display("[TB] FAIL %s outs: got %b expected %b (t=%0t)", name, act, exp_outs, $time);
        end
        vectors++;
        if (instr_cnt !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL %s cnt: got %0d expected %0d (t=%0t)", name, instr_cnt, exp_cnt, $time);
        end
        vectors++;
        if (w_act !== exp_outs) begin
            miscompares++;
            $display("[TB] FAIL %s wrap outs: got %b expected %b (t=%0t)", name, w_act, exp_outs, $time);
        end
        vectors++;
        if (w_instr_cnt !== exp_cnt[1:0]) begin
            miscompares++;
            $display("[TB] FAIL %s wrap cnt: got %0d expected %0d (t=%0t)", name, w_instr_cnt, exp_cnt[1:0], $time);
        end
    endtask

    // Drives inputs at the falling edge, lets one rising edge pass and
    // returns at the next falling edge, where outputs are stable.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic zf, input logic res);
        instr_valid = v;
        opcode      = op;
        zero_flag   = zf;
        resume      = res;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        opcode      = 4'hF;
        zero_flag   = 1'b0;
        resume      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_held", O_IDLE, 8'd0);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        checkOutput("reset_release", O_IDLE, 8'd0);
        modelReset();
    endtask

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic       zf;
        logic       res;
        logic [4:0] exp_outs;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t       tv[22];
    logic [1:0] wrap_exp[5];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Each row: inputs driven this cycle, outputs expected before they are driven.
        tv[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, O_IDLE, 8'd0};
        tv[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, O_BUSY, 8'd0};
        tv[2]  = '{1'b1, 4'h4, 1'b0, 1'b0, O_EXEC, 8'd0};
        tv[3]  = '{1'b1, 4'h4, 1'b0, 1'b0, O_IDLE, 8'd1};
        tv[4]  = '{1'b0, 4'h4, 1'b0, 1'b0, O_BUSY, 8'd1};
        tv[5]  = '{1'b0, 4'h4, 1'b0, 1'b0, O_JMP1, 8'd1};
        tv[6]  = '{1'b0, 4'h4, 1'b0, 1'b0, O_JMPN, 8'd1};
        tv[7]  = '{1'b1, 4'h3, 1'b0, 1'b0, O_IDLE, 8'd2};
        tv[8]  = '{1'b0, 4'h3, 1'b1, 1'b0, O_BUSY, 8'd2};
        tv[9]  = '{1'b0, 4'h3, 1'b0, 1'b0, O_JMP1, 8'd2};
        tv[10] = '{1'b0, 4'h3, 1'b1, 1'b0, O_JMPN, 8'd2};
        tv[11] = '{1'b1, 4'h3, 1'b1, 1'b0, O_IDLE, 8'd3};
        tv[12] = '{1'b0, 4'h3, 1'b0, 1'b0, O_BUSY, 8'd3};
        tv[13] = '{1'b0, 4'h3, 1'b1, 1'b0, O_EXEC, 8'd3};
        tv[14] = '{1'b1, 4'h0, 1'b0, 1'b0, O_IDLE, 8'd4};
        tv[15] = '{1'b1, 4'h0, 1'b0, 1'b0, O_BUSY, 8'd4};
        tv[16] = '{1'b1, 4'h0, 1'b0, 1'b0, O_HALT, 8'd5};
        tv[17] = '{1'b1, 4'h0, 1'b0, 1'b1, O_HALT, 8'd5};
        tv[18] = '{1'b1, 4'hF, 1'b0, 1'b1, O_IDLE, 8'd5};
        tv[19] = '{1'b0, 4'hF, 1'b0, 1'b1, O_BUSY, 8'd5};
        tv[20] = '{1'b0, 4'hF, 1'b0, 1'b0, O_EXEC, 8'd5};
        tv[21] = '{1'b0, 4'hF, 1'b0, 1'b0, O_IDLE, 8'd6};

        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        // Table of basic opcode classes.
        doReset();
        for (int i = 0; i < 22; i++) begin
            checkOutput($sformatf("table[%0d]", i), tv[i].exp_outs, tv[i].exp_cnt);
            applyStimulus(tv[i].valid, tv[i].op, tv[i].zf, tv[i].res);
        end

        // Long halt with valid held high, then a single resume pulse.
        doReset();
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_hold", O_HALT, 8'd1);
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        end
        checkOutput("halt_hold", O_HALT, 8'd1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
        checkOutput("halt_resume", O_IDLE, 8'd1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("halt_next_accept", O_BUSY, 8'd1);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput("halt_next_exec", O_EXEC, 8'd1);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
        checkOutput("halt_next_retire", O_IDLE, 8'd2);

        // Asynchronous reset in the middle of a jump, between clock edges.
        applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h4, 1'b0, 1'b0);
        checkOutput("jump_before_reset", O_JMP1, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", O_IDLE, 8'd0);
        @(negedge clk);
        checkOutput("async_reset_hold", O_IDLE, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        modelReset();

        // Counter wrap on the 2-bit instance.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
            applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
            applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
            vectors++;
            if (w_instr_cnt !== wrap_exp[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap[%0d]: got %0d expected %0d", i, w_instr_cnt, wrap_exp[i]);
            end
        end

        // Random traffic against the reference model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            logic       v;
            logic [3:0] op;
            logic       zf;
            logic       res;
            int unsigned sel;
            checkOutput("random", modelOuts(), retired[7:0]);
            v   = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       op = 4'b0000;
                1:       op = 4'b0100;
                2, 3:    op = 4'b0011;
                default: op = 4'($urandom);
            endcase
            zf  = 1'($urandom_range(0, 1));
            res = ($urandom_range(0, 4) == 0);
            modelAdvance(v, op, zf, res);
            applyStimulus(v, op, zf, res);
        end
        checkOutput("random_end", modelOuts(), retired[7:0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
